// File: rtl/apb_timer.sv
// APB down-counting timer with reload, an optional external clock/enable
// input and a level interrupt. Zero-wait-state slave; never signals errors.
module apb_timer #(
  parameter int WIDTH = 32  // counter/reload width; only 32 is supported
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             PSEL,
  input  logic [5:0]       PADDR,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [WIDTH-1:0] PWDATA,
  output logic [WIDTH-1:0] PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  input  logic             EXTIN,
  output logic             TIMERINT
);

  localparam logic [5:0] ADDR_CTRL   = 6'd0;
  localparam logic [5:0] ADDR_VALUE  = 6'd1;
  localparam logic [5:0] ADDR_RELOAD = 6'd2;
  localparam logic [5:0] ADDR_INT    = 6'd3;

  // ctrl = {IRQEN, EXTCLK, EXTEN, EN}
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] reload;
  logic             int_status;

  logic ext_meta, ext_s, ext_d;
  logic wr_en, wr_ctrl, wr_value, wr_reload, wr_int;
  logic rise, tick, int_set;

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  assign wr_en     = PSEL & PENABLE & PWRITE;
  assign wr_ctrl   = wr_en & (PADDR == ADDR_CTRL);
  assign wr_value  = wr_en & (PADDR == ADDR_VALUE);
  assign wr_reload = wr_en & (PADDR == ADDR_RELOAD);
  assign wr_int    = wr_en & (PADDR == ADDR_INT);

  assign rise = ext_s & ~ext_d;
  assign tick = ctrl[0] & (~ctrl[1] | ext_s) & (ctrl[2] ? rise : 1'b1);

  // A VALUE write on a tick cycle discards that tick, including the
  // interrupt it would have raised.
  assign int_set = tick & ~wr_value & (value == WIDTH'(1));

  assign TIMERINT = int_status & ctrl[3];

  // EXTIN is asynchronous: two flops to resolve metastability, a third
  // to remember the previous synchronised level for edge detection.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ext_meta <= 1'b0;
      ext_s    <= 1'b0;
      ext_d    <= 1'b0;
    end else begin
      ext_meta <= EXTIN;
      ext_s    <= ext_meta;
      ext_d    <= ext_s;
    end
  end

  // Control and reload registers; RELOAD only reaches VALUE on a reload event.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl   <= '0;
      reload <= '0;
    end else begin
      if (wr_ctrl)   ctrl   <= PWDATA[3:0];
      if (wr_reload) reload <= PWDATA;
    end
  end

  // Counter: bus write has priority over a tick; 1 and 0 both reload.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      value <= '0;
    end else if (wr_value) begin
      value <= PWDATA;
    end else if (tick) begin
      if (value > WIDTH'(1)) value <= value - WIDTH'(1);
      else                   value <= reload;
    end
  end

  // Interrupt status: set beats a simultaneous write-1-to-clear.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                 int_status <= 1'b0;
    else if (int_set)             int_status <= 1'b1;
    else if (wr_int && PWDATA[0]) int_status <= 1'b0;
  end

  // Read mux, only driven during a read selection.
  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (PADDR)
        ADDR_CTRL:   PRDATA = {{(WIDTH-4){1'b0}}, ctrl};
        ADDR_VALUE:  PRDATA = value;
        ADDR_RELOAD: PRDATA = reload;
        ADDR_INT:    PRDATA = {{(WIDTH-1){1'b0}}, int_status};
        default:     PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_timer.sv
// Self-checking bench for apb_timer: directed scenarios plus randomized
// enable windows checked against a closed-form count model.
module tb_apb_timer;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0;
  logic [5:0]  PADDR = '0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        EXTIN = 1'b0;
  logic        TIMERINT;

  int tests = 0;
  int fails = 0;

  apb_timer #(.WIDTH(32)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .EXTIN(EXTIN), .TIMERINT(TIMERINT)
  );

  always #5 PCLK = ~PCLK;

  // advance n clock edges, ending 1 time unit past the last one
  task automatic cyc(input int n);
    repeat (n) begin @(posedge PCLK); #1; end
  endtask

  // two-phase APB write; the register updates on the second edge
  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  // combinational read between edges; takes 1 time unit
  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    #1;
    d = PRDATA;
    PSEL = 1'b0;
  endtask

  // Closed-form expectation after k ticks from VALUE=v0 with RELOAD=r.
  task automatic model(input int v0, input int r, input int k,
                       output int val, output bit irq);
    int v, kk;
    v = v0; kk = k; irq = 1'b0;
    if (v == 0 && kk > 0) begin v = r; kk = kk - 1; end
    if (v == 0)          val = 0;
    else if (kk < v)     val = v - kk;
    else begin
      irq = 1'b1;
      kk  = kk - v;
      val = (r == 0) ? 0 : r - (kk % r);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    PRESETn = 1'b0;
    #3;
    tests++; if (TIMERINT !== 1'b0) begin fails++; $display("FAIL reset_timerint got %0b want 0", TIMERINT); end
    tests++; if (PREADY !== 1'b1) begin fails++; $display("FAIL reset_pready got %0b want 1", PREADY); end
    tests++; if (PSLVERR !== 1'b0) begin fails++; $display("FAIL reset_pslverr got %0b want 0", PSLVERR); end
    for (int i = 0; i < 4; i++) begin
      rd(6'(i), d);
      tests++; if (d !== 32'd0) begin fails++; $display("FAIL reset_reg%0d got %h want 0", i, d); end
    end
    cyc(3);
    PRESETn = 1'b1;
    cyc(2);
    rd(6'd1, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL post_reset_value got %h want 0", d); end
  endtask

  task automatic test_periodic();
    logic [31:0] d;
    int exp_v [10] = '{4, 3, 2, 1, 5, 4, 3, 2, 1, 5};
    wr(6'd3, 32'd1);
    wr(6'd2, 32'd5);
    wr(6'd1, 32'd5);
    wr(6'd0, 32'h9);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      rd(6'd1, d);
      tests++; if (d !== 32'(exp_v[i])) begin fails++; $display("FAIL periodic_value[%0d] got %0d want %0d", i, d, exp_v[i]); end
      tests++; if (TIMERINT !== (i >= 4)) begin fails++; $display("FAIL periodic_timerint[%0d] got %0b want %0b", i, TIMERINT, (i >= 4)); end
      if (i == 4) begin
        rd(6'd3, d);
        tests++; if (d !== 32'd1) begin fails++; $display("FAIL periodic_intstatus got %h want 1", d); end
      end
    end
  endtask

  task automatic test_intclear();
    logic [31:0] d;
    wr(6'd0, 32'h8);
    tests++; if (TIMERINT !== 1'b1) begin fails++; $display("FAIL clear_before got %0b want 1", TIMERINT); end
    wr(6'd3, 32'd0);
    tests++; if (TIMERINT !== 1'b1) begin fails++; $display("FAIL clear_write0 got %0b want 1", TIMERINT); end
    wr(6'd3, 32'd1);
    tests++; if (TIMERINT !== 1'b0) begin fails++; $display("FAIL clear_after got %0b want 0", TIMERINT); end
    // clear lands on the same edge as a set
    wr(6'd2, 32'd5);
    wr(6'd1, 32'd2);
    wr(6'd0, 32'h9);
    wr(6'd3, 32'd1);
    rd(6'd3, d);
    tests++; if (d !== 32'd1) begin fails++; $display("FAIL set_beats_clear got %h want 1", d); end
    tests++; if (TIMERINT !== 1'b1) begin fails++; $display("FAIL set_beats_clear_int got %0b want 1", TIMERINT); end
    rd(6'd1, d);
    tests++; if (d !== 32'd5) begin fails++; $display("FAIL set_beats_clear_value got %0d want 5", d); end
    wr(6'd0, 32'h0);
    wr(6'd3, 32'd1);
  endtask

  task automatic test_extclk();
    logic [31:0] d;
    int exp_v [3] = '{2, 1, 3};
    wr(6'd1, 32'd3);
    wr(6'd2, 32'd3);
    wr(6'd3, 32'd1);
    wr(6'd0, 32'h5);
    for (int e = 0; e < 3; e++) begin
      EXTIN = 1'b1;
      for (int c = 1; c <= 3; c++) begin
        cyc(1);
        rd(6'd1, d);
        if (c < 3) begin
          tests++; if (d !== 32'(e == 0 ? 3 : exp_v[e-1])) begin fails++; $display("FAIL extclk_early[%0d.%0d] got %0d want %0d", e, c, d, (e == 0 ? 3 : exp_v[e-1])); end
        end else begin
          tests++; if (d !== 32'(exp_v[e])) begin fails++; $display("FAIL extclk_edge[%0d] got %0d want %0d", e, d, exp_v[e]); end
        end
      end
      cyc(5);
      rd(6'd1, d);
      tests++; if (d !== 32'(exp_v[e])) begin fails++; $display("FAIL extclk_held[%0d] got %0d want %0d", e, d, exp_v[e]); end
      EXTIN = 1'b0;
      cyc(4);
    end
    rd(6'd3, d);
    tests++; if (d !== 32'd1) begin fails++; $display("FAIL extclk_int got %h want 1", d); end
    tests++; if (TIMERINT !== 1'b0) begin fails++; $display("FAIL extclk_irqen_off got %0b want 0", TIMERINT); end
    wr(6'd0, 32'h0);
    wr(6'd3, 32'd1);
  endtask

  task automatic test_exten();
    logic [31:0] d;
    int exp_v [7] = '{10, 10, 9, 8, 7, 6, 6};
    EXTIN = 1'b0;
    cyc(3);
    wr(6'd1, 32'd10);
    wr(6'd2, 32'd10);
    wr(6'd0, 32'h3);
    cyc(4);
    rd(6'd1, d);
    tests++; if (d !== 32'd10) begin fails++; $display("FAIL exten_frozen got %0d want 10", d); end
    EXTIN = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 4) EXTIN = 1'b0;
      cyc(1);
      rd(6'd1, d);
      tests++; if (d !== 32'(exp_v[c])) begin fails++; $display("FAIL exten_value[%0d] got %0d want %0d", c, d, exp_v[c]); end
    end
    wr(6'd0, 32'h0);
  endtask

  task automatic test_write_tick();
    logic [31:0] d;
    wr(6'd3, 32'd1);
    wr(6'd2, 32'd7);
    wr(6'd1, 32'd2);
    wr(6'd0, 32'h1);
    wr(6'd1, 32'd100);
    rd(6'd1, d);
    tests++; if (d !== 32'd100) begin fails++; $display("FAIL write_tick_value got %0d want 100", d); end
    rd(6'd3, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL write_tick_noint got %h want 0", d); end
    wr(6'd0, 32'h0);
    rd(6'd1, d);
    tests++; if (d !== 32'd98) begin fails++; $display("FAIL write_tick_freeze got %0d want 98", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    wr(6'd0, 32'hFFFF_FFF0);
    rd(6'd0, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL ctrl_upper got %h want 0", d); end
    wr(6'd0, 32'h0);
    wr(6'd1, 32'h1234);
    wr(6'd2, 32'h5678);
    for (int i = 0; i < 6; i++) begin
      logic [5:0] a;
      a = 6'($urandom_range(4, 63));
      wr(a, $urandom);
      rd(a, d);
      tests++; if (d !== 32'd0) begin fails++; $display("FAIL unmapped_read[%0d] got %h want 0", a, d); end
    end
    rd(6'd1, d);
    tests++; if (d !== 32'h1234) begin fails++; $display("FAIL unmapped_value got %h want 1234", d); end
    rd(6'd2, d);
    tests++; if (d !== 32'h5678) begin fails++; $display("FAIL unmapped_reload got %h want 5678", d); end
    PADDR = 6'd1; PSEL = 1'b0; #1;
    tests++; if (PRDATA !== 32'd0) begin fails++; $display("FAIL prdata_unselected got %h want 0", PRDATA); end
    tests++; if (PSLVERR !== 1'b0 || PREADY !== 1'b1) begin fails++; $display("FAIL resp got pslverr=%0b pready=%0b want 0/1", PSLVERR, PREADY); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    int v0, r, w, val;
    bit irq, irqen;
    for (int it = 0; it < 24; it++) begin
      irqen = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 12));
      v0 = int'($urandom_range(0, 12));
      w  = int'($urandom_range(0, 30));
      wr(6'd0, {28'd0, irqen, 3'b000});
      wr(6'd3, 32'd1);
      wr(6'd2, 32'(r));
      wr(6'd1, 32'(v0));
      wr(6'd0, {28'd0, irqen, 3'b001});
      cyc(w);
      wr(6'd0, {28'd0, irqen, 3'b000});
      model(v0, r, w + 2, val, irq);
      rd(6'd1, d);
      tests++; if (d !== 32'(val)) begin fails++; $display("FAIL random_value[%0d] v0=%0d r=%0d k=%0d got %0d want %0d", it, v0, r, w + 2, d, val); end
      rd(6'd3, d);
      tests++; if (d !== {31'd0, irq}) begin fails++; $display("FAIL random_int[%0d] got %h want %0b", it, d, irq); end
      tests++; if (TIMERINT !== (irq & irqen)) begin fails++; $display("FAIL random_timerint[%0d] got %0b want %0b", it, TIMERINT, irq & irqen); end
    end
    wr(6'd0, 32'h0);
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    wr(6'd3, 32'd1);
    wr(6'd2, 32'd3);
    wr(6'd1, 32'd3);
    wr(6'd0, 32'h9);
    cyc(3);
    tests++; if (TIMERINT !== 1'b1) begin fails++; $display("FAIL arst_pre got %0b want 1", TIMERINT); end
    #2;
    PRESETn = 1'b0;
    #1;
    tests++; if (TIMERINT !== 1'b0) begin fails++; $display("FAIL arst_timerint got %0b want 0", TIMERINT); end
    for (int i = 0; i < 4; i++) begin
      rd(6'(i), d);
      tests++; if (d !== 32'd0) begin fails++; $display("FAIL arst_reg%0d got %h want 0", i, d); end
    end
    cyc(2);
    PRESETn = 1'b1;
    cyc(10);
    rd(6'd1, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL arst_idle_value got %h want 0", d); end
    rd(6'd0, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL arst_idle_ctrl got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_intclear();
    test_extclk();
    test_exten();
    test_write_tick();
    test_unmapped();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // hard stop in case a scenario stalls
  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/apb_timer.md
APB_TIMER -- requirements
Module: apb_timer

Interface
REQ-001 Parameter: WIDTH, 32, counter and reload register width (fixed at 32; no other value supported).
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 PCLK  input  1  APB clock; all state on rising edge.
REQ-004 PRESETn  input  1  asynchronous active-low reset.
REQ-005 PSEL  input  1  slave select from APB slave mux.
REQ-006 PADDR  input  6  word address (bus PADDR[7:2]).
REQ-007 PENABLE  input  1  APB access phase.
REQ-008 PWRITE  input  1  1 = write, 0 = read.
REQ-009 PWDATA  input  32  write data.
REQ-010 PRDATA  output  32  read data.
REQ-011 PREADY  output  1  tied 1; no wait states.
REQ-012 PSLVERR  output  1  tied 0.
REQ-013 EXTIN  input  1  external input, asynchronous to PCLK.
REQ-014 TIMERINT  output  1  interrupt, active high, level.

Function
REQ-015 Register map (PADDR word index): 0 CTRL, 1 VALUE, 2 RELOAD, 3 INTSTATUS/INTCLEAR; all other indices read 0, writes ignored.
REQ-016 CTRL[3:0] = {IRQEN, EXTCLK, EXTEN, EN}; bits [31:4] read 0, writes to them ignored.
REQ-017 Write strobe = PSEL & PENABLE & PWRITE; registers update on the following PCLK edge.
REQ-018 PRDATA = selected register when PSEL & ~PWRITE, else 0; combinational from registers.
REQ-019 EXTIN passes a 2-flop synchroniser (ext_s); a third flop holds ext_d; rise = ext_s & ~ext_d.
REQ-020 Tick = EN & (~EXTEN | ext_s) & (EXTCLK ? rise : 1).
REQ-021 On tick: VALUE > 1 -> VALUE-1; VALUE == 1 -> VALUE <= RELOAD and INTSTATUS[0] <= 1; VALUE == 0 -> VALUE <= RELOAD, no interrupt.
REQ-022 Period with EN only = RELOAD cycles per interrupt (RELOAD != 0); RELOAD = 0 and VALUE = 0 -> counter stays 0, no interrupt.
REQ-023 APB write to VALUE in the same cycle as a tick: the write wins; the tick is discarded.
REQ-024 APB write to RELOAD affects VALUE only at the next reload event.
REQ-025 Writing 1 to INTSTATUS[0] clears it; writing 0 has no effect; reads return {31'b0, INTSTATUS[0]}.
REQ-026 Set and clear in the same cycle: set wins, INTSTATUS[0] = 1.
REQ-027 INTSTATUS[0] sets regardless of IRQEN; TIMERINT = INTSTATUS[0] & IRQEN, combinational.
REQ-028 Clearing EN freezes VALUE; INTSTATUS is held.

Reset
REQ-029 PRESETn low asynchronously clears CTRL, VALUE, RELOAD, INTSTATUS and all synchroniser flops to 0.
REQ-030 During and after reset: TIMERINT = 0, PRDATA = 0, PREADY = 1, PSLVERR = 0.
REQ-031 Reset asserted mid-count abandons the count; after release the timer is idle until CTRL is rewritten.

Verification
REQ-032 RELOAD=5, VALUE=5, CTRL=0x9 -> VALUE 4,3,2,1 on successive cycles, then 5; INTSTATUS=1 and TIMERINT=1 on the reload edge; repeats every 5 cycles.
REQ-033 INTSTATUS=1, write INTCLEAR=1 -> TIMERINT falls the cycle after the write; write in the same cycle as a set -> stays 1.
REQ-034 CTRL=0x5 (EN, EXTCLK), VALUE=3, three EXTIN rising edges -> VALUE decrements once per edge, 3 PCLK after each edge; held-high EXTIN gives no further decrements.
REQ-035 CTRL=0x3 (EN, EXTEN), EXTIN low -> VALUE frozen; EXTIN high -> decrement every cycle from the 3rd cycle after the rise.
REQ-036 Write VALUE=100 in the same cycle as a tick -> readback 100; reads of index 4-63 -> 0; PSLVERR = 0 throughout.
REQ-037 PRESETn pulsed low while counting with TIMERINT=1 -> all registers read 0 and TIMERINT=0 immediately, without waiting for a PCLK edge.
